// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter that drives a shared 4:1 mux.
//
// A two-state FSM (idle/grant) picks the first pending requester searched circularly
// from the one after the last owner. The grant lasts while the owner keeps its
// request high. Every grant is followed by exactly one idle cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to compile in a hold counter. With it, an
// owner that has held for MAX_HOLD cycles is forced off when another requester is
// waiting.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request lines, held high by each requester until it is done
//   a,b,c,d    data from requesters 0..3
//   gnt[3:0]   registered one-hot grant
//   sel[1:0]   registered index of the current or last owner (mux select)
//   y          shared mux output; 0 while no grant is active
//   valid      high exactly when gnt is nonzero
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       y,
  output logic       valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  // Circular priority search starting just after the last owner.
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = ptr_q;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  logic rel_now;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       contend;

  assign contend = |(req & ~gnt_q);
  assign rel_now = !req[sel_q] || ((hold_q == HoldMax) && contend);

  // Counts grant cycles; zero throughout idle so it is clear on every grant entry.
  always_comb begin
    hold_d = hold_q;
    if (state_q == StIdle) begin
      hold_d = '0;
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign rel_now = !req[sel_q];
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'(4'b0001 << winner);
          sel_d   = winner;
          ptr_d   = winner;
        end
      end
      StGrant: begin
        // sel keeps the last owner through the idle cycle.
        if (rel_now) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  logic mux_out;

  always_comb begin
    unique case (sel_q)
      2'd0:    mux_out = a;
      2'd1:    mux_out = b;
      2'd2:    mux_out = c;
      default: mux_out = d;
    endcase
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;
  assign y     = valid & mux_out;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a behavioural model predicts the state after
// every edge and queues it; a monitor checks the DUT one time unit after each edge.
module tb_mux_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       valid;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .gnt  (gnt),
    .sel  (sel),
    .y    (y),
    .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: who owns the bus (-1 = nobody), last owner, cycles held.
  int   m_owner = -1;
  int   m_ptr   = 3;
  int   m_hold  = 0;
  int   m_run   = 0;
  int   m_sel   = 0;

  int   starts[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  // Predict the effect of the coming edge given the inputs just applied.
  task automatic model_edge(input logic r, input logic [3:0] rq);
    exp_t  e;
    bit    drop;
    if (r) begin
      m_owner = -1; m_ptr = 3; m_hold = 0; m_sel = 0; m_run = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_ptr = m_owner; m_sel = m_owner; m_hold = 0; m_run = 1;
      end
    end else begin
      drop = !rq[m_owner];
`ifdef ARB_TIMEOUT_EN
      if (m_hold == int'(MAX_HOLD) - 1 && (rq & ~(4'b0001 << m_owner)) != 4'b0000) drop = 1'b1;
`endif
      if (drop) begin
        m_owner = -1;
      end else begin
        m_run++;
        if (m_hold < int'(MAX_HOLD) - 1) m_hold++;
      end
    end
    e.gnt = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
    e.sel = 2'(m_sel);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    req = rq;
    {a, b, c, d} = 4'($urandom);
    model_edge(r, rq);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [3:0] dat;
    logic       want_y;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        dat    = {d, c, b, a};
        want_y = (e.gnt != 4'b0000) ? dat[e.sel] : 1'b0;
        chk("gnt", int'(gnt), int'(e.gnt));
        chk("sel", int'(sel), int'(e.sel));
        chk("valid", int'(valid), int'(e.gnt != 4'b0000));
        chk("y", int'(y), int'(want_y));
        chk("onehot", int'($onehot0(gnt)), 1);
      end
      if (valid && !prev_valid) starts.push_back(int'(sel));
      prev_valid = valid;
    end
  end

  initial begin
    logic [3:0] r;
    logic       rr;
    int         order[5] = '{0, 1, 2, 3, 0};

    // Reset state, then a single requester (2) for three cycles.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    repeat (3) step(1'b0, 4'b0100);
    repeat (3) step(1'b0, 4'b0000);

    // All request; each owner drops for one cycle after two granted cycles.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
    @(negedge clk);
    starts.delete();
    repeat (30) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_run >= 2) r[m_owner] = 1'b0;
      step(1'b0, r);
    end
    step(1'b0, 4'b0000);
    @(negedge clk);
    chk("grant_count", int'(starts.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < starts.size()) chk("rotation", starts[i], order[i]);
    end

    // Owner 1 with 0011 held, then release: next grant wraps to 0.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0010);
    repeat (3) step(1'b0, 4'b0011);
    repeat (3) step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);

    // Reset in the middle of owner 2's grant, then everyone requests.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    repeat (4) step(1'b0, 4'b1111);

    // Contention between 0 and 3, then a lone requester for 20 cycles.
    step(1'b1, 4'b0000);
    repeat (20) step(1'b0, 4'b1001);
    step(1'b0, 4'b0000);
    repeat (20) step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);

    // Randomised traffic with occasional resets.
    repeat (400) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      rr = ($urandom_range(0, 39) == 0);
      step(rr, r);
    end
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive grant cycles per owner when the timeout is compiled in; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: request lines; req[i] held high by requester i until it is done.
REQ-005 The block SHALL have ports a, b, c, d, input, 1 bit each: data from requesters 0, 1, 2 and 3.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 2 bits: binary index of the current or last owner, registered; drives the shared 4:1 mux.
REQ-008 The block SHALL have port y, output, 1 bit: shared mux output.
REQ-009 The block SHALL have port valid, output, 1 bit: high exactly when gnt is nonzero.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 IDLE: gnt SHALL be 4'b0000.
REQ-012 IDLE: if req is nonzero at an edge, the FSM SHALL enter GRANT and set gnt and sel to the winner at that edge, giving one cycle of latency from req to gnt.
REQ-013 The winner SHALL be the first set req bit searched circularly from index (ptr+1) mod 4, where ptr is the index of the last owner.
REQ-014 On each grant, ptr SHALL update to the winner's index.
REQ-015 GRANT: gnt and sel SHALL hold while req[sel] is high.
REQ-016 GRANT: the first edge with req[sel] low SHALL clear gnt and return the FSM to IDLE.
REQ-017 Every two consecutive grants SHALL be separated by exactly one IDLE cycle with gnt=0.
REQ-018 Arbitration SHALL consider only the req value sampled at the edge; changes to other req bits during GRANT SHALL have no effect.
REQ-019 y SHALL equal a, b, c or d for sel 0, 1, 2 or 3 when valid=1, and SHALL be 0 when valid=0; it is combinational from the registered sel and gnt.
REQ-020 gnt SHALL never have more than one bit set, in any cycle.
REQ-021 A requester that drops req in the same cycle it is granted SHALL still receive one GRANT cycle, then release under REQ-016.
REQ-022 If req=4'b1111 continuously, grants SHALL rotate 0,1,2,3,0 after reset, each followed by release when the owner drops its req.

Reset
REQ-023 With rst high at an edge, the block SHALL set state=IDLE, gnt=0, sel=0, valid=0 and ptr=3, so that requester 0 has first priority after reset.
REQ-024 When reset is applied during GRANT, it SHALL take effect at that edge with no release cycle; y SHALL read 0 in the following cycle.
REQ-025 Reset SHALL take priority over every other event.
REQ-026 The hold counter SHALL clear to 0 on reset.

Configuration
REQ-027 The timeout SHALL be compiled in only when the macro ARB_TIMEOUT_EN is defined.
REQ-028 With ARB_TIMEOUT_EN defined, a hold counter SHALL count GRANT cycles.
REQ-029 With ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 while req[sel] is still high and any other req bit is high, the next edge SHALL force release to IDLE.
REQ-030 A forced release SHALL behave as a normal release: ptr already equals the owner, so the owner loses priority.
REQ-031 With ARB_TIMEOUT_EN defined and no other requester pending, the owner SHALL hold indefinitely, with the counter saturating at MAX_HOLD-1.
REQ-032 The counter SHALL clear on each entry to GRANT.
REQ-033 Without ARB_TIMEOUT_EN, no counter SHALL exist and an owner SHALL hold until it drops req.

Verification
REQ-034 Reset, then req=4'b0100 for 3 cycles then 0: gnt=4'b0100 and sel=2 one cycle after req; y follows c; gnt=0 one cycle after req drops.
REQ-035 Reset, then req=4'b1111, each owner dropping its req after 2 granted cycles and re-raising it: grant order 0,1,2,3,0; one gnt=0 cycle between grants; gnt stays one-hot.
REQ-036 Owner 1 granted with req=4'b0011 held: after release, next grant is 0 (wrap from ptr=1 skips 2 and 3).
REQ-037 Reset asserted mid-GRANT with owner 2: next cycle gnt=0, sel=0, valid=0, y=0; then req=4'b1111 grants requester 0 first.
REQ-038 With ARB_TIMEOUT_EN and MAX_HOLD=4, req=4'b1001 held constantly: requester 0 holds 4 cycles, 1 idle cycle, requester 3 holds 4 cycles, and the pattern repeats.
REQ-039 With ARB_TIMEOUT_EN and only req[2] high for 20 cycles: gnt=4'b0100 holds for all 20 cycles with no forced release.
